// File: rtl/axi_lite_slaver_regfile_if.sv
// AXI4-Lite slave-side bundle for the register file; master drives addresses/data, slave drives readies/responses.
interface axi_lite_slaver_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_slaver_regfile.sv
// AXI4-Lite register file with byte strobes, read-only and write-one-to-clear registers.
// B rises one edge after both AW and W are held; R loads on the AR edge; AW/W/AR stall while their response is pending.
module axi_lite_slaver_regfile #(
  parameter int                 C_S_AXI_DATA_WIDTH = 32,
  parameter int                 REG_NUM            = 16,
  parameter int                 C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [REG_NUM-1:0] RO_MASK            = '0,
  parameter logic [REG_NUM-1:0] W1C_MASK           = '0
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  axi_lite_slaver_regfile_if.slave              s_axi,
  output logic [REG_NUM*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [REG_NUM*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [REG_NUM-1:0]                    reg_wr_pulse
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int IW  = AW - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              aw_held, w_held;
  logic [IW-1:0]     aw_idx;
  logic [DW-1:0]     w_data;
  logic [SW-1:0]     w_strb;
  logic              bvalid, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     regs [REG_NUM];

  logic              aw_fire, w_fire, ar_fire, commit;
  logic [DW-1:0]     w_mask;
  logic [REG_NUM-1:0] wr_sel;
  logic              wr_err;
  logic [IW-1:0]     ar_idx;
  logic [DW-1:0]     rd_val;
  logic [1:0]        rd_resp;

  assign s_axi.S_AXI_AWREADY = !ARESET && !aw_held && !bvalid;
  assign s_axi.S_AXI_WREADY  = !ARESET && !w_held && !bvalid;
  assign s_axi.S_AXI_ARREADY = !ARESET && !rvalid;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RDATA   = rdata;

  assign aw_fire = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_fire  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_fire = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign commit  = aw_held && w_held;
  assign ar_idx  = s_axi.S_AXI_ARADDR[AW-1:LSB];

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < SW; k++) w_mask[k*8 +: 8] = {8{w_strb[k]}};
  end

  // Out-of-range and read-only targets both fall through to SLVERR with no select.
  always_comb begin
    wr_sel = '0;
    wr_err = 1'b1;
    for (int i = 0; i < REG_NUM; i++) begin
      if (int'(aw_idx) == i) begin
        wr_err    = RO_MASK[i];
        wr_sel[i] = !RO_MASK[i];
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < REG_NUM; i++) begin
      if (int'(ar_idx) == i) begin
        rd_resp = RESP_OKAY;
        rd_val  = RO_MASK[i] ? reg_in[i*DW +: DW] : regs[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      rvalid       <= 1'b0;
      rresp        <= RESP_OKAY;
      rdata        <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.S_AXI_AWADDR[AW-1:LSB];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        bvalid       <= 1'b1;
        bresp        <= wr_err ? RESP_SLVERR : RESP_OKAY;
        reg_wr_pulse <= wr_sel;
      end else if (bvalid && s_axi.S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (ar_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_resp;
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // W1C: the set term is OR'd after the clear so a same-cycle set wins.
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (ARESET) begin
        regs[i] <= '0;
      end else if (RO_MASK[i]) begin
        regs[i] <= reg_in[i*DW +: DW];
      end else if (W1C_MASK[i]) begin
        regs[i] <= (regs[i] & ~(w_data & w_mask & {DW{commit && wr_sel[i]}}))
                   | reg_in[i*DW +: DW];
      end else if (commit && wr_sel[i]) begin
        regs[i] <= (regs[i] & ~w_mask) | (w_data & w_mask);
      end
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs[g];
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0], reg_in};

endmodule

// File: tb/tb_axi_lite_slaver_regfile.sv
// Bench for axi_lite_slaver_regfile: vector table, hand-written corner sequences, then random traffic against a register model.
module tb_axi_lite_slaver_regfile;
  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int NREG    = 16;
  localparam int RO_IDX  = 9;
  localparam int W1C_IDX = 10;
  localparam logic [NREG-1:0] RO_M  = 16'h0200;
  localparam logic [NREG-1:0] W1C_M = 16'h0400;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int TMO = 40;

  logic                 ACLK   = 1'b0;
  logic                 ARESET = 1'b1;
  logic [NREG*DW-1:0]   reg_out;
  logic [NREG*DW-1:0]   reg_in = '0;
  logic [NREG-1:0]      reg_wr_pulse;

  axi_lite_slaver_regfile_if #(.DW(DW), .AW(AW)) bus ();

  axi_lite_slaver_regfile #(
    .C_S_AXI_DATA_WIDTH(DW), .REG_NUM(NREG), .C_S_AXI_ADDR_WIDTH(AW),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus),
    .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int pulse_cnt [NREG];
  logic [DW-1:0] mdl [NREG];

  always @(negedge ACLK)
    for (int i = 0; i < NREG; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no handshake after %0d cycles, expected one", name, TMO);
  endtask

  task automatic skip(input int n);
    repeat (n) @(posedge ACLK);
    if (n > 0) #1;
  endtask

  task automatic aw_send(input logic [AW-1:0] a, input int dly);
    logic hs; int n;
    skip(dly);
    bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1; n = 0;
    do begin
      @(negedge ACLK); hs = bus.S_AXI_AWREADY;
      @(posedge ACLK); n++;
    end while (!hs && n < TMO);
    if (!hs) timeout("aw_handshake");
    #1 bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int dly);
    logic hs; int n;
    skip(dly);
    bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1; n = 0;
    do begin
      @(negedge ACLK); hs = bus.S_AXI_WREADY;
      @(posedge ACLK); n++;
    end while (!hs && n < TMO);
    if (!hs) timeout("w_handshake");
    #1 bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] a, input int dly);
    logic hs; int n;
    skip(dly);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; n = 0;
    do begin
      @(negedge ACLK); hs = bus.S_AXI_ARREADY;
      @(posedge ACLK); n++;
    end while (!hs && n < TMO);
    if (!hs) timeout("ar_handshake");
    #1 bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic b_wait(input int dly, output logic [1:0] resp);
    logic v; int n;
    skip(dly);
    bus.S_AXI_BREADY = 1'b1; n = 0; resp = 2'bxx;
    do begin
      @(negedge ACLK); v = bus.S_AXI_BVALID; resp = bus.S_AXI_BRESP;
      @(posedge ACLK); n++;
    end while (!v && n < TMO);
    if (!v) timeout("b_handshake");
    #1 bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic r_wait(input int dly, output logic [DW-1:0] d, output logic [1:0] resp);
    logic v; int n;
    skip(dly);
    bus.S_AXI_RREADY = 1'b1; n = 0; d = 'x; resp = 2'bxx;
    do begin
      @(negedge ACLK); v = bus.S_AXI_RVALID; d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
      @(posedge ACLK); n++;
    end while (!v && n < TMO);
    if (!v) timeout("r_handshake");
    #1 bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    fork
      aw_send(a, aw_dly);
      w_send(d, s, w_dly);
    join
    b_wait(b_dly, resp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                         output logic [DW-1:0] d, output logic [1:0] resp);
    ar_send(a, ar_dly);
    r_wait(r_dly, d, resp);
  endtask

  // Reference model: register index is the word address, strobes select bytes.
  task automatic mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                           output logic [1:0] resp);
    int idx;
    idx  = int'(a) / (DW/8);
    resp = SLVERR;
    if (idx < NREG) begin
      if (!RO_M[idx]) begin
        resp = OKAY;
        for (int k = 0; k < DW/8; k++)
          if (s[k]) begin
            if (W1C_M[idx]) mdl[idx][k*8 +: 8] = mdl[idx][k*8 +: 8] & ~d[k*8 +: 8];
            else            mdl[idx][k*8 +: 8] = d[k*8 +: 8];
          end
      end
    end
  endtask

  task automatic mdl_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(a) / (DW/8);
    d = '0; resp = SLVERR;
    if (idx < NREG) begin
      resp = OKAY;
      d = RO_M[idx] ? reg_in[idx*DW +: DW] : mdl[idx];
    end
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
  } vec_t;
  vec_t vt [$];

  initial begin
    logic [1:0]         resp, er;
    logic [DW-1:0]      d, ed;
    logic [NREG*DW-1:0] masked;
    int                 psum;

    vt.push_back('{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,        OKAY});
    vt.push_back('{1'b1, 8'h04, 32'h2,        4'hF, 32'h0,        OKAY});
    vt.push_back('{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        OKAY});
    vt.push_back('{1'b1, 8'h0C, 32'h4,        4'hF, 32'h0,        OKAY});
    vt.push_back('{1'b0, 8'h00, 32'h0,        4'h0, 32'h1,        OKAY});
    vt.push_back('{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        OKAY});
    vt.push_back('{1'b0, 8'h08, 32'h0,        4'h0, 32'h3,        OKAY});
    vt.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 32'h4,        OKAY});
    vt.push_back('{1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        OKAY});
    vt.push_back('{1'b1, 8'h08, 32'h00000000, 4'h2, 32'h0,        OKAY});
    vt.push_back('{1'b0, 8'h08, 32'h0,        4'h0, 32'hFFFF00FF, OKAY});
    vt.push_back('{1'b0, 8'h0B, 32'h0,        4'h0, 32'hFFFF00FF, OKAY});
    vt.push_back('{1'b1, 8'h40, 32'h11111111, 4'hF, 32'h0,        SLVERR});
    vt.push_back('{1'b1, 8'hFC, 32'h22222222, 4'hF, 32'h0,        SLVERR});
    vt.push_back('{1'b1, 8'h24, 32'h33333333, 4'hF, 32'h0,        SLVERR});
    vt.push_back('{1'b0, 8'h24, 32'h0,        4'h0, 32'h0000A5A5, OKAY});
    vt.push_back('{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,        SLVERR});
    vt.push_back('{1'b0, 8'h43, 32'h0,        4'h0, 32'h0,        SLVERR});

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    reg_in[RO_IDX*DW +: DW] = 32'h0000A5A5;
    for (int i = 0; i < NREG; i++) mdl[i] = '0;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready_low", bus.S_AXI_AWREADY, 0);
    check("rst_wready_low", bus.S_AXI_WREADY, 0);
    check("rst_arready_low", bus.S_AXI_ARREADY, 0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_awready", bus.S_AXI_AWREADY, 1);
    check("post_rst_wready", bus.S_AXI_WREADY, 1);
    check("post_rst_arready", bus.S_AXI_ARREADY, 1);
    check("post_rst_bvalid", bus.S_AXI_BVALID, 0);
    check("post_rst_rvalid", bus.S_AXI_RVALID, 0);
    check("post_rst_resps", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 0);
    check("post_rst_rdata", bus.S_AXI_RDATA, 0);
    check("post_rst_pulse", reg_wr_pulse, 0);
    masked = reg_out; masked[RO_IDX*DW +: DW] = '0;
    check("post_rst_reg_out", masked[63:0] | masked[NREG*DW-1:NREG*DW-64], 0);
    @(posedge ACLK); #1;

    // Vector table
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, 0, resp);
        mdl_write(vt[i].addr, vt[i].data, vt[i].strb, er);
        check($sformatf("vec%0d_bresp", i), resp, vt[i].exp_resp);
      end else begin
        do_read(vt[i].addr, 0, 0, d, resp);
        check($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        check($sformatf("vec%0d_rresp", i), resp, vt[i].exp_resp);
      end
    end
    @(negedge ACLK);
    check("arready_after_r_hs", bus.S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;
    check("pulse_reg0", pulse_cnt[0], 1);
    check("pulse_reg1", pulse_cnt[1], 1);
    check("pulse_reg2", pulse_cnt[2], 3);
    check("pulse_reg3", pulse_cnt[3], 1);
    check("pulse_ro", pulse_cnt[RO_IDX], 0);
    psum = 0;
    for (int i = 0; i < NREG; i++) psum += pulse_cnt[i];
    check("pulse_total", psum, 6);

    // W presented three cycles ahead of AW
    bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge ACLK); check("wfirst_wready_pre", bus.S_AXI_WREADY, 1);
    @(posedge ACLK); #1 bus.S_AXI_WVALID = 1'b0;
    @(negedge ACLK); check("wfirst_wready_held", bus.S_AXI_WREADY, 0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWADDR = 8'h10; bus.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK); check("wfirst_awready", bus.S_AXI_AWREADY, 1);
    @(posedge ACLK); #1 bus.S_AXI_AWVALID = 1'b0;
    @(negedge ACLK); check("wfirst_bvalid_early", bus.S_AXI_BVALID, 0);
    @(posedge ACLK);
    @(negedge ACLK);
    mdl_write(8'h10, 32'hDEADBEEF, 4'hF, er);
    check("wfirst_bvalid", bus.S_AXI_BVALID, 1);
    check("wfirst_bresp", bus.S_AXI_BRESP, er);
    check("wfirst_reg_out", reg_out[4*DW +: DW], 32'hDEADBEEF);
    check("wfirst_pulse", reg_wr_pulse, 16'h0010);
    @(posedge ACLK); #1 bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 bus.S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("wfirst_bvalid_clr", bus.S_AXI_BVALID, 0);
    check("wfirst_pulse_once", reg_wr_pulse, 0);
    check("wfirst_awready_again", bus.S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;

    // W1C register: sticky set, clear, set wins over same-cycle clear
    reg_in[W1C_IDX*DW] = 1'b1;
    @(posedge ACLK); #1 reg_in[W1C_IDX*DW] = 1'b0;
    mdl[W1C_IDX] = mdl[W1C_IDX] | 32'h1;
    do_read(8'h28, 0, 0, d, resp); check("w1c_set", d, 32'h1);
    skip(3);
    do_read(8'h28, 0, 0, d, resp); check("w1c_sticky", d, 32'h1);
    do_write(8'h28, 32'h1, 4'hF, 0, 0, 0, resp); mdl_write(8'h28, 32'h1, 4'hF, er);
    check("w1c_clear_bresp", resp, er);
    do_read(8'h28, 0, 0, d, resp); check("w1c_cleared", d, 32'h0);
    reg_in[W1C_IDX*DW] = 1'b1;
    do_write(8'h28, 32'h1, 4'hF, 0, 0, 0, resp);
    #1 reg_in[W1C_IDX*DW] = 1'b0;
    mdl[W1C_IDX] = 32'h1;
    do_read(8'h28, 0, 0, d, resp); check("w1c_set_wins", d, 32'h1);
    do_write(8'h28, 32'h1, 4'hF, 0, 0, 0, resp); mdl_write(8'h28, 32'h1, 4'hF, er);
    do_read(8'h28, 0, 0, d, resp); check("w1c_cleared_again", d, 32'h0);

    // Reset while B and R are both pending
    fork
      aw_send(8'h14, 0);
      w_send(32'h12345678, 4'hF, 0);
      ar_send(8'h10, 0);
    join
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("hold_bvalid", bus.S_AXI_BVALID, 1);
    check("hold_rvalid", bus.S_AXI_RVALID, 1);
    check("hold_rdata", bus.S_AXI_RDATA, 32'hDEADBEEF);
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_bvalid", bus.S_AXI_BVALID, 0);
    check("midrst_rvalid", bus.S_AXI_RVALID, 0);
    check("midrst_awready", bus.S_AXI_AWREADY, 1);
    masked = reg_out; masked[RO_IDX*DW +: DW] = '0;
    check("midrst_reg4", masked[4*DW +: DW], 0);
    check("midrst_reg5", masked[5*DW +: DW], 0);
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    @(posedge ACLK); #1;
    do_read(8'h10, 0, 0, d, resp); check("midrst_read4", d, 32'h0);
    do_read(8'h08, 0, 0, d, resp); check("midrst_read2", d, 32'h0);
    do_write(8'h14, 32'hCAFEF00D, 4'hF, 1, 0, 1, resp); mdl_write(8'h14, 32'hCAFEF00D, 4'hF, er);
    check("midrst_wr_bresp", resp, OKAY);
    do_read(8'h14, 0, 0, d, resp); check("midrst_readback", d, 32'hCAFEF00D);

    // Random traffic against the model
    for (int it = 0; it < 80; it++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] dd;
      logic [3:0]    ss;
      int            idx;
      a   = AW'($urandom_range(0, 'h4F));
      dd  = $urandom;
      ss  = 4'($urandom_range(0, 15));
      idx = int'(a) / 4;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, dd, ss, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
        mdl_write(a, dd, ss, er);
        check($sformatf("rnd%0d_bresp", it), resp, er);
        if (idx < NREG && !RO_M[idx])
          check($sformatf("rnd%0d_reg_out", it), reg_out[idx*DW +: DW], mdl[idx]);
      end else begin
        mdl_read(a, ed, er);
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, resp);
        check($sformatf("rnd%0d_rdata", it), d, ed);
        check($sformatf("rnd%0d_rresp", it), resp, er);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
